// File: rtl/ccss_trace_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ccss_trace_capture
// Description : Timestamped, change-compressed trace recorder for multicore1.
//               While running, an entry is stored whenever the control word or
//               the Z flag changes, on the very first enabled cycle, and on the
//               end-of-program cycle. Storage is a circular buffer that keeps
//               the newest DEPTH entries. When endp arrives the recorder
//               freezes, and the buffer is popped oldest-first through rd_en.
//
// Ports       : clk2        - system clock, rising edge
//               controlRST  - synchronous active-high reset
//               clock_en    - run enable; gates capture and timestamp
//               bus_in      - multicore1 bus_out      (24 bits)
//               ctrlsig_in  - multicore1 ctrlsig_out  (25 bits)
//               z_in        - multicore1 Zout
//               endp_in     - multicore1 endp
//               rd_en       - pop request, honoured only when frozen
//               rd_data     - popped entry {ts, end_mark, z, ctrlsig, bus}
//               rd_valid    - one-cycle pulse qualifying rd_data
//               entry_count - entries currently held
//               overflow    - sticky, set once any entry is overwritten
//               capturing   - recorder is in the capture state
//               frozen      - recorder is frozen and readable
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ccss_trace_capture #(
   parameter int DEPTH = 256,
   parameter int TS_W  = 16
) (
   input  logic                        clk2,
   input  logic                        controlRST,
   input  logic                        clock_en,
   input  logic [23:0]                 bus_in,
   input  logic [24:0]                 ctrlsig_in,
   input  logic                        z_in,
   input  logic                        endp_in,
   input  logic                        rd_en,
   output logic [TS_W+50:0]            rd_data,
   output logic                        rd_valid,
   output logic [$clog2(DEPTH):0]      entry_count,
   output logic                        overflow,
   output logic                        capturing,
   output logic                        frozen
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH) + 1;
   localparam int c_ew = TS_W + 51;

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_capture = 2'd1;
   localparam logic [1:0] c_st_frozen  = 2'd2;

   localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
   localparam logic [TS_W-1:0] c_ts_one  = TS_W'(1);
   localparam logic [TS_W-1:0] c_ts_max  = {TS_W{1'b1}};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic [TS_W-1:0]  r_ts;
   logic [24:0]      r_prev_ctrl;
   logic             r_prev_z;
   logic             r_ovf;
   logic [c_ew-1:0]  r_rd_data;
   logic             r_rd_valid;
   logic [c_ew-1:0]  r_mem [DEPTH];

   logic             w_sample;
   logic             w_first;
   logic             w_change;
   logic             w_write;
   logic             w_full;
   logic             w_pop;
   logic [c_ew-1:0]  w_entry;

   // The IDLE cycle that sees clock_en is itself a capture cycle, so the
   // sampling qualifier covers both IDLE and CAPTURE.
   assign w_sample = clock_en && ((r_state == c_st_idle) || (r_state == c_st_capture));
   assign w_first  = (r_state == c_st_idle);
   assign w_change = (ctrlsig_in != r_prev_ctrl) || (z_in != r_prev_z);
   assign w_write  = w_sample && (w_first || w_change || endp_in);
   assign w_full   = (r_count == c_full);
   // Writes happen only before freezing and pops only after, so the two are
   // never active in the same cycle.
   assign w_pop    = (r_state == c_st_frozen) && rd_en && (r_count != '0);
   assign w_entry  = {r_ts, endp_in, z_in, ctrlsig_in, bus_in};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle,
         c_st_capture: begin
            if (clock_en) begin
               w_state_nxt = endp_in ? c_st_frozen : c_st_capture;
            end
         end
         c_st_frozen:  w_state_nxt = c_st_frozen;
         default:      w_state_nxt = c_st_idle;
      endcase
   end

   // Trace storage: single write port, registered read port, no reset so it
   // maps onto block RAM.
   always_ff @(posedge clk2) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk2) begin
      if (controlRST) begin
         r_state     <= c_st_idle;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ts        <= '0;
         r_prev_ctrl <= '0;
         r_prev_z    <= 1'b0;
         r_ovf       <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= w_pop;

         if (w_sample) begin
            r_prev_ctrl <= ctrlsig_in;
            r_prev_z    <= z_in;
            if (r_ts != c_ts_max) begin
               r_ts <= r_ts + c_ts_one;
            end
         end

         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_full) begin
               // Buffer full: the oldest entry is dropped by moving the read
               // pointer along with the write pointer.
               r_rd_ptr <= r_rd_ptr + c_ptr_one;
               r_ovf    <= 1'b1;
            end else begin
               r_count  <= r_count + c_cnt_one;
            end
         end else if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + c_ptr_one;
            r_count   <= r_count - c_cnt_one;
         end
      end
   end

   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign entry_count = r_count;
   assign overflow    = r_ovf;
   assign capturing   = (r_state == c_st_capture);
   assign frozen      = (r_state == c_st_frozen);

endmodule
`default_nettype wire

// File: tb/tb_ccss_trace_capture.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ccss_trace_capture
// Description : Self-checking bench for ccss_trace_capture (DEPTH=4, TS_W=8).
//               A queue-based reference model predicts buffer contents and
//               status; popped entries are queued as expected read responses
//               and matched by an independent monitor on rd_valid.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ccss_trace_capture;

   localparam int DEPTH = 4;
   localparam int TS_W  = 8;
   localparam int EW    = TS_W + 51;
   localparam int TS_MAX = (1 << TS_W) - 1;

   logic                  clk2;
   logic                  controlRST;
   logic                  clock_en;
   logic [23:0]           bus_in;
   logic [24:0]           ctrlsig_in;
   logic                  z_in;
   logic                  endp_in;
   logic                  rd_en;
   logic [EW-1:0]         rd_data;
   logic                  rd_valid;
   logic [$clog2(DEPTH):0] entry_count;
   logic                  overflow;
   logic                  capturing;
   logic                  frozen;

   ccss_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk2        (clk2),
      .controlRST  (controlRST),
      .clock_en    (clock_en),
      .bus_in      (bus_in),
      .ctrlsig_in  (ctrlsig_in),
      .z_in        (z_in),
      .endp_in     (endp_in),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .entry_count (entry_count),
      .overflow    (overflow),
      .capturing   (capturing),
      .frozen      (frozen)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n    = 0;
   always @(posedge clk2) cyc_n <= cyc_n + 1;

   // Reference model state
   logic [EW-1:0] m_q[$];
   bit            m_started;
   bit            m_frozen;
   bit            m_ovf;
   int            m_ts;
   logic [24:0]   m_pc;
   logic          m_pz;

   // Scoreboard of expected read responses
   logic [EW-1:0] exp_q[$];
   int            exp_cyc[$];
   logic [EW-1:0] m_hold;
   bit            mon_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_started = 1'b0;
      m_frozen  = 1'b0;
      m_ovf     = 1'b0;
      m_ts      = 0;
      m_pc      = '0;
      m_pz      = 1'b0;
   endtask

   task automatic check_status();
      chk("entry_count", int'(entry_count), m_q.size());
      chk("overflow",    int'(overflow),    int'(m_ovf));
      chk("frozen",      int'(frozen),      int'(m_frozen));
      chk("capturing",   int'(capturing),   int'(m_started && !m_frozen));
   endtask

   // One clock: apply inputs, advance the model, clock, then check status.
   task automatic cyc(input bit en, input logic [24:0] ctrl, input bit z,
                      input bit endp, input bit rden);
      logic [23:0] bus;
      bus        = 24'($urandom);
      clock_en   = en;
      ctrlsig_in = ctrl;
      z_in       = z;
      endp_in    = endp;
      rd_en      = rden;
      bus_in     = bus;
      if (!m_frozen) begin
         if (en) begin
            if (!m_started || ctrl != m_pc || z != m_pz || endp) begin
               m_q.push_back({m_ts[TS_W-1:0], endp, z, ctrl, bus});
               if (m_q.size() > DEPTH) begin
                  void'(m_q.pop_front());
                  m_ovf = 1'b1;
               end
            end
            if (m_ts < TS_MAX) m_ts++;
            m_pc = ctrl;
            m_pz = z;
            m_started = 1'b1;
            if (endp) m_frozen = 1'b1;
         end
      end else if (rden && m_q.size() > 0) begin
         exp_q.push_back(m_q.pop_front());
         exp_cyc.push_back(cyc_n + 1);
      end
      @(posedge clk2);
      #1;
      check_status();
   endtask

   task automatic do_reset();
      controlRST = 1'b1;
      clock_en   = 1'b0;
      endp_in    = 1'b0;
      rd_en      = 1'b0;
      model_reset();
      @(posedge clk2);
      #1;
      m_hold     = '0;
      controlRST = 1'b0;
      chk("rst_count",    int'(entry_count), 0);
      chk("rst_overflow", int'(overflow),    0);
      chk("rst_capturing",int'(capturing),   0);
      chk("rst_frozen",   int'(frozen),      0);
      chk("rst_rd_valid", int'(rd_valid),    0);
      chk("rst_rd_data_zero", int'(rd_data == '0), 1);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 25'h0, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: matches each rd_valid pulse against the scoreboard and checks
   // rd_data holds its value between pulses.
   always @(negedge clk2) begin
      if (mon_on) begin
         n_checks++;
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL rd_valid_spurious: got rd_valid=1 data=%h expected no pulse", rd_data);
            end else begin
               logic [EW-1:0] e;
               int            c;
               e = exp_q.pop_front();
               c = exp_cyc.pop_front();
               if (rd_data !== e || cyc_n != c) begin
                  n_errors++;
                  $display("FAIL rd_entry: got data=%h at cycle %0d expected data=%h at cycle %0d",
                           rd_data, cyc_n, e, c);
               end
               m_hold = e;
            end
         end else if (rd_data !== m_hold) begin
            n_errors++;
            $display("FAIL rd_data_hold: got %h expected %h", rd_data, m_hold);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [24:0] c;
      bit          zz;
      int          len;

      controlRST = 1'b1;
      clock_en   = 1'b0;
      bus_in     = '0;
      ctrlsig_in = '0;
      z_in       = 1'b0;
      endp_in    = 1'b0;
      rd_en      = 1'b0;
      m_hold     = '0;
      model_reset();
      @(posedge clk2);
      #1;
      do_reset();
      mon_on = 1'b1;

      // Constant control word for 5 cycles, then endp: two entries.
      for (int i = 0; i < 5; i++) cyc(1'b1, 25'h1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 25'h1, 1'b0, 1'b1, 1'b0);
      chk("t1_count", int'(entry_count), 2);
      chk("t1_frozen", int'(frozen), 1);
      chk("t1_overflow", int'(overflow), 0);
      // Six consecutive pops with two entries held.
      drain(6);
      chk("t1_empty", int'(entry_count), 0);
      cyc(1'b0, 25'h0, 1'b0, 1'b0, 1'b0);

      // Toggling control word overflows the buffer.
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, 25'(i & 1), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 25'h1, 1'b0, 1'b1, 1'b0);
      chk("t2_count", int'(entry_count), 4);
      chk("t2_overflow", int'(overflow), 1);
      drain(5);

      // clock_en low mid-run while inputs change.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 25'h5, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 25'h7, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 25'h9, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 25'hA, 1'b1, 1'b0, 1'b0);
      chk("t3_not_frozen", int'(frozen), 0);
      chk("t3_count", int'(entry_count), 1);
      cyc(1'b1, 25'hA, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 25'hA, 1'b1, 1'b1, 1'b0);
      drain(4);

      // Reset mid-capture, then again mid-readout.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 25'(i), 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 25'(i * 3), 1'(i), 1'b0, 1'b0);
      cyc(1'b1, 25'h3, 1'b1, 1'b1, 1'b0);
      drain(1);
      do_reset();
      cyc(1'b1, 25'h2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 25'h4, 1'b0, 1'b1, 1'b0);
      drain(3);

      // Long constant run: timestamp saturates.
      do_reset();
      for (int i = 0; i < 300; i++) cyc(1'b1, 25'h1ABCDE, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 25'h1ABCDE, 1'b0, 1'b1, 1'b0);
      chk("t5_count", int'(entry_count), 2);
      drain(3);

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         do_reset();
         c   = 25'($urandom);
         zz  = 1'b0;
         len = $urandom_range(3, 40);
         for (int i = 0; i < len; i++) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) c = 25'($urandom);
            if ($urandom_range(0, 5) == 0) zz = ~zz;
            cyc(en, c, zz, en ? 1'b0 : 1'($urandom), 1'($urandom));
         end
         cyc(1'b1, c, zz, 1'b1, 1'b0);
         for (int i = 0; i < DEPTH + 4; i++)
            cyc(1'b0, 25'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      drain(2);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
